mc_controller: RTL and testbench

Multi-cycle control FSM for the RV32I core. It sequences a shared ALU, a single unified memory port and the register file across several cycles per instruction. It decodes `op`/`funct3` from the instruction register and drives the mux selects, write enables and memory request for the multi-cycle datapath variant. It also stalls on a memory-ready handshake and flags illegal opcodes.

---
 rtl/mc_controller_if.sv | 41 ++++
 rtl/mc_controller.sv | 193 +++++++++++++++++++
 tb/tb_mc_controller.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mc_controller_if.sv
// ============================================================================
// Module      : mc_controller_if
// Description : Control bundle between the multi-cycle controller and datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mc_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       Taken;
  logic       MemReady;
  logic       MemReq;
  logic       MemWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       PCClrLsb;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       Retire;
  logic       Illegal;

  modport master (
    input  op, funct3, Taken, MemReady,
    output MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, PCClrLsb, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Retire, Illegal
  );

  modport slave (
    output op, funct3, Taken, MemReady,
    input  MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, PCClrLsb, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Retire, Illegal
  );
endinterface

`default_nettype wire

// File: rtl/mc_controller.sv
// ============================================================================
// Module      : mc_controller
// Description : Multi-cycle RV32I control FSM driving the shared ALU, unified
//               memory port and register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_controller (
  input  wire logic      clk,
  input  wire logic      reset,
  mc_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALR_PC  = 4'd12,
    S_LUI      = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       w_memreq, w_memwrite, w_adrsrc, w_irwrite, w_pcwrite;
  logic       w_pcclrlsb, w_regwrite, w_retire, w_illegal;
  logic [1:0] w_resultsrc, w_alusrca, w_alusrcb;
  logic [2:0] w_immsrc;
  logic [3:0] w_aluctrl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_memreq    = 1'b0;
    w_memwrite  = 1'b0;
    w_adrsrc    = 1'b0;
    w_irwrite   = 1'b0;
    w_pcwrite   = 1'b0;
    w_pcclrlsb  = 1'b0;
    w_regwrite  = 1'b0;
    w_retire    = 1'b0;
    w_illegal   = 1'b0;
    w_resultsrc = 2'b00;
    w_alusrca   = 2'b00;
    w_alusrcb   = 2'b00;
    w_aluctrl   = 4'b0000;
    case (bus.op)
      7'b0100011:             w_immsrc = 3'b001;
      7'b1100011:             w_immsrc = 3'b010;
      7'b1101111:             w_immsrc = 3'b011;
      7'b0110111, 7'b0010111: w_immsrc = 3'b100;
      default:                w_immsrc = 3'b000;
    endcase

    case (r_state)
      S_FETCH: begin
        w_memreq    = 1'b1;
        w_alusrcb   = 2'b10;
        w_resultsrc = 2'b10;
        if (bus.MemReady) begin
          w_irwrite = 1'b1;
          w_pcwrite = 1'b1;
          w_next    = S_DECODE;
        end
      end
      // ALUOut captures OldPC+imm here so branches and AUIPC can reuse it
      S_DECODE: begin
        w_alusrca = 2'b01;
        w_alusrcb = 2'b01;
        case (bus.op)
          7'b0000011, 7'b0100011: w_next = S_MEMADR;
          7'b0110011:             w_next = S_EXEC_R;
          7'b0010011:             w_next = S_EXEC_I;
          7'b1100011:             w_next = S_BRANCH;
          7'b1101111:             w_next = S_JAL;
          7'b1100111:             w_next = S_JALR;
          7'b0110111:             w_next = S_LUI;
          7'b0010111:             w_next = S_ALUWB;
          default:                w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 2'b10;
        w_alusrcb = 2'b01;
        w_next    = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_memreq = 1'b1;
        w_adrsrc = 1'b1;
        if (bus.MemReady) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_resultsrc = 2'b01;
        w_regwrite  = 1'b1;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWRITE: begin
        w_memreq   = 1'b1;
        w_memwrite = 1'b1;
        w_adrsrc   = 1'b1;
        if (bus.MemReady) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_EXEC_R: begin
        w_alusrca = 2'b10;
        w_aluctrl = {1'b1, bus.funct3};
        w_next    = S_ALUWB;
      end
      // funct3=000 forces ADD: Instr[30] of an ADDI is immediate data
      S_EXEC_I: begin
        w_alusrca = 2'b10;
        w_alusrcb = 2'b01;
        w_aluctrl = (bus.funct3 == 3'b000) ? 4'b0000 : {1'b1, bus.funct3};
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        w_alusrca = 2'b10;
        w_pcwrite = bus.Taken;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      S_JAL: begin
        w_pcwrite = 1'b1;
        w_alusrca = 2'b01;
        w_alusrcb = 2'b10;
        w_next    = S_ALUWB;
      end
      S_JALR: begin
        w_alusrca = 2'b10;
        w_alusrcb = 2'b01;
        w_next    = S_JALR_PC;
      end
      S_JALR_PC: begin
        w_pcwrite  = 1'b1;
        w_pcclrlsb = 1'b1;
        w_alusrca  = 2'b01;
        w_alusrcb  = 2'b10;
        w_next     = S_ALUWB;
      end
      S_LUI: begin
        w_alusrca = 2'b11;
        w_alusrcb = 2'b01;
        w_next    = S_ALUWB;
      end
      S_TRAP: begin
        w_illegal = 1'b1;
        w_next    = S_TRAP;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Reset gates every output so nothing leaks out while reset is held low
  assign bus.MemReq     = reset & w_memreq;
  assign bus.MemWrite   = reset & w_memwrite;
  assign bus.AdrSrc     = reset & w_adrsrc;
  assign bus.IRWrite    = reset & w_irwrite;
  assign bus.PCWrite    = reset & w_pcwrite;
  assign bus.PCClrLsb   = reset & w_pcclrlsb;
  assign bus.RegWrite   = reset & w_regwrite;
  assign bus.Retire     = reset & w_retire;
  assign bus.Illegal    = reset & w_illegal;
  assign bus.ResultSrc  = reset ? w_resultsrc : 2'b00;
  assign bus.ALUSrcA    = reset ? w_alusrca   : 2'b00;
  assign bus.ALUSrcB    = reset ? w_alusrcb   : 2'b00;
  assign bus.ImmSrc     = reset ? w_immsrc    : 3'b000;
  assign bus.ALUControl = reset ? w_aluctrl   : 4'b0000;

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// ============================================================================
// Module      : tb_mc_controller
// Description : Directed cycle-by-cycle vector bench for mc_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_controller;

  localparam logic [6:0] c_R     = 7'b0110011;
  localparam logic [6:0] c_I     = 7'b0010011;
  localparam logic [6:0] c_LW    = 7'b0000011;
  localparam logic [6:0] c_SW    = 7'b0100011;
  localparam logic [6:0] c_BR    = 7'b1100011;
  localparam logic [6:0] c_JAL   = 7'b1101111;
  localparam logic [6:0] c_JALR  = 7'b1100111;
  localparam logic [6:0] c_LUI   = 7'b0110111;
  localparam logic [6:0] c_AUIPC = 7'b0010111;
  localparam logic [6:0] c_BAD   = 7'b1111111;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mc_controller_if bus();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        tk;
    logic        mr;
    logic [21:0] exp;
  } vec_t;

  vec_t vecs[$];

  // {MemReq,MemWrite,AdrSrc,IRWrite,PCWrite,PCClrLsb,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,Retire,Illegal}
  function automatic logic [21:0] mk(input logic mq, mw, ad, ir, pw, cl, rw,
                                     input logic [1:0] rs, a, b,
                                     input logic [2:0] im, input logic [3:0] al,
                                     input logic rt, il);
    return {mq, mw, ad, ir, pw, cl, rw, rs, a, b, im, al, rt, il};
  endfunction

  function automatic logic [21:0] e_fetch(input logic [2:0] im, input logic mr);
    return mk(1'b1, 1'b0, 1'b0, mr, mr, 1'b0, 1'b0, 2'd2, 2'd0, 2'd2, im, 4'd0, 1'b0, 1'b0);
  endfunction

  function automatic logic [21:0] e_dec(input logic [2:0] im);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, im, 4'd0, 1'b0, 1'b0);
  endfunction

  function automatic logic [21:0] e_wb(input logic [2:0] im);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, im, 4'd0, 1'b1, 1'b0);
  endfunction

  function automatic logic [21:0] pk();
    return {bus.MemReq, bus.MemWrite, bus.AdrSrc, bus.IRWrite, bus.PCWrite,
            bus.PCClrLsb, bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
            bus.ImmSrc, bus.ALUControl, bus.Retire, bus.Illegal};
  endfunction

  task automatic v(input string nm, input logic rst, input logic [6:0] o,
                   input logic [2:0] f, input logic tk, input logic mr,
                   input logic [21:0] e);
    vec_t t;
    t.name = nm; t.rst = rst; t.op = o; t.f3 = f; t.tk = tk; t.mr = mr; t.exp = e;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [21:0] e);
    logic [21:0] act;
    act = pk();
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, act, e);
    end
  endtask

  initial begin
    bus.op = c_R; bus.funct3 = 3'd0; bus.Taken = 1'b0; bus.MemReady = 1'b1;

    // reset held low for three cycles
    for (int i = 0; i < 3; i++) v("reset", 1'b0, c_R, 3'd0, 1'b0, 1'b1, 22'd0);
    // ADD
    v("add_fetch", 1'b1, c_R, 3'd0, 1'b0, 1'b1, e_fetch(3'd0, 1'b1));
    v("add_dec",   1'b1, c_R, 3'd0, 1'b0, 1'b1, e_dec(3'd0));
    v("add_exec",  1'b1, c_R, 3'd0, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd0,3'd0,4'b1000,1'b0,1'b0));
    v("add_wb",    1'b1, c_R, 3'd0, 1'b0, 1'b1, e_wb(3'd0));
    // LW with two wait cycles in MEMREAD
    v("lw_fetch",  1'b1, c_LW, 3'd2, 1'b0, 1'b1, e_fetch(3'd0, 1'b1));
    v("lw_dec",    1'b1, c_LW, 3'd2, 1'b0, 1'b1, e_dec(3'd0));
    v("lw_adr",    1'b1, c_LW, 3'd2, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd1,3'd0,4'd0,1'b0,1'b0));
    v("lw_rd_w1",  1'b1, c_LW, 3'd2, 1'b0, 1'b0, mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,3'd0,4'd0,1'b0,1'b0));
    v("lw_rd_w2",  1'b1, c_LW, 3'd2, 1'b0, 1'b0, mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,3'd0,4'd0,1'b0,1'b0));
    v("lw_rd",     1'b1, c_LW, 3'd2, 1'b0, 1'b1, mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,3'd0,4'd0,1'b0,1'b0));
    v("lw_wb",     1'b1, c_LW, 3'd2, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd1,2'd0,2'd0,3'd0,4'd0,1'b1,1'b0));
    // SW with a wait in FETCH and in MEMWRITE
    v("sw_fetch_w", 1'b1, c_SW, 3'd2, 1'b0, 1'b0, e_fetch(3'd1, 1'b0));
    v("sw_fetch",   1'b1, c_SW, 3'd2, 1'b0, 1'b1, e_fetch(3'd1, 1'b1));
    v("sw_dec",     1'b1, c_SW, 3'd2, 1'b0, 1'b1, e_dec(3'd1));
    v("sw_adr",     1'b1, c_SW, 3'd2, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd1,3'd1,4'd0,1'b0,1'b0));
    v("sw_wr_w",    1'b1, c_SW, 3'd2, 1'b0, 1'b0, mk(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,3'd1,4'd0,1'b0,1'b0));
    v("sw_wr",      1'b1, c_SW, 3'd2, 1'b0, 1'b1, mk(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,3'd1,4'd0,1'b1,1'b0));
    // BEQ not taken (MemReady low in DECODE/BRANCH is ignored), then taken
    v("beq0_fetch", 1'b1, c_BR, 3'd0, 1'b0, 1'b1, e_fetch(3'd2, 1'b1));
    v("beq0_dec",   1'b1, c_BR, 3'd0, 1'b0, 1'b0, e_dec(3'd2));
    v("beq0_br",    1'b1, c_BR, 3'd0, 1'b0, 1'b0, mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd0,3'd2,4'd0,1'b1,1'b0));
    v("beq1_fetch", 1'b1, c_BR, 3'd0, 1'b1, 1'b1, e_fetch(3'd2, 1'b1));
    v("beq1_dec",   1'b1, c_BR, 3'd0, 1'b1, 1'b1, e_dec(3'd2));
    v("beq1_br",    1'b1, c_BR, 3'd0, 1'b1, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,2'd2,2'd0,3'd2,4'd0,1'b1,1'b0));
    // ADDI and SRAI
    v("addi_fetch", 1'b1, c_I, 3'd0, 1'b0, 1'b1, e_fetch(3'd0, 1'b1));
    v("addi_dec",   1'b1, c_I, 3'd0, 1'b0, 1'b1, e_dec(3'd0));
    v("addi_exec",  1'b1, c_I, 3'd0, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd1,3'd0,4'b0000,1'b0,1'b0));
    v("addi_wb",    1'b1, c_I, 3'd0, 1'b0, 1'b1, e_wb(3'd0));
    v("srai_fetch", 1'b1, c_I, 3'd5, 1'b0, 1'b1, e_fetch(3'd0, 1'b1));
    v("srai_dec",   1'b1, c_I, 3'd5, 1'b0, 1'b1, e_dec(3'd0));
    v("srai_exec",  1'b1, c_I, 3'd5, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd1,3'd0,4'b1101,1'b0,1'b0));
    v("srai_wb",    1'b1, c_I, 3'd5, 1'b0, 1'b1, e_wb(3'd0));
    // JAL
    v("jal_fetch",  1'b1, c_JAL, 3'd0, 1'b0, 1'b1, e_fetch(3'd3, 1'b1));
    v("jal_dec",    1'b1, c_JAL, 3'd0, 1'b0, 1'b1, e_dec(3'd3));
    v("jal_pc",     1'b1, c_JAL, 3'd0, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,2'd1,2'd2,3'd3,4'd0,1'b0,1'b0));
    v("jal_wb",     1'b1, c_JAL, 3'd0, 1'b0, 1'b1, e_wb(3'd3));
    // JALR
    v("jalr_fetch", 1'b1, c_JALR, 3'd0, 1'b0, 1'b1, e_fetch(3'd0, 1'b1));
    v("jalr_dec",   1'b1, c_JALR, 3'd0, 1'b0, 1'b1, e_dec(3'd0));
    v("jalr_tgt",   1'b1, c_JALR, 3'd0, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd1,3'd0,4'd0,1'b0,1'b0));
    v("jalr_pc",    1'b1, c_JALR, 3'd0, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd0,2'd1,2'd2,3'd0,4'd0,1'b0,1'b0));
    v("jalr_wb",    1'b1, c_JALR, 3'd0, 1'b0, 1'b1, e_wb(3'd0));
    // LUI and AUIPC
    v("lui_fetch",  1'b1, c_LUI, 3'd0, 1'b0, 1'b1, e_fetch(3'd4, 1'b1));
    v("lui_dec",    1'b1, c_LUI, 3'd0, 1'b0, 1'b1, e_dec(3'd4));
    v("lui_exec",   1'b1, c_LUI, 3'd0, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd3,2'd1,3'd4,4'd0,1'b0,1'b0));
    v("lui_wb",     1'b1, c_LUI, 3'd0, 1'b0, 1'b1, e_wb(3'd4));
    v("auipc_fetch", 1'b1, c_AUIPC, 3'd0, 1'b0, 1'b1, e_fetch(3'd4, 1'b1));
    v("auipc_dec",   1'b1, c_AUIPC, 3'd0, 1'b0, 1'b1, e_dec(3'd4));
    v("auipc_wb",    1'b1, c_AUIPC, 3'd0, 1'b0, 1'b1, e_wb(3'd4));
    // reset in EXEC_R aborts the instruction, then an illegal opcode
    v("abort_fetch", 1'b1, c_R, 3'd0, 1'b0, 1'b1, e_fetch(3'd0, 1'b1));
    v("abort_dec",   1'b1, c_R, 3'd0, 1'b0, 1'b1, e_dec(3'd0));
    v("abort_rst",   1'b0, c_R, 3'd0, 1'b0, 1'b1, 22'd0);
    v("bad_fetch",   1'b1, c_BAD, 3'd0, 1'b0, 1'b1, e_fetch(3'd0, 1'b1));
    v("bad_dec",     1'b1, c_BAD, 3'd0, 1'b0, 1'b1, e_dec(3'd0));
    v("bad_trap",    1'b1, c_BAD, 3'd0, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,3'd0,4'd0,1'b0,1'b1));

    foreach (vecs[i]) begin
      @(negedge clk);
      reset        = vecs[i].rst;
      bus.op       = vecs[i].op;
      bus.funct3   = vecs[i].f3;
      bus.Taken    = vecs[i].tk;
      bus.MemReady = vecs[i].mr;
      #1;
      chk(vecs[i].name, vecs[i].exp);
    end

    // TRAP must hold for 20 more cycles regardless of MemReady/Taken
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.MemReady = i[0];
      bus.Taken    = i[1];
      #1;
      chk("trap_hold", mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,3'd0,4'd0,1'b0,1'b1));
    end

    // asynchronous reset away from any clock edge
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("trap_async_rst", 22'd0);
    @(negedge clk);
    reset        = 1'b1;
    bus.op       = c_R;
    bus.MemReady = 1'b1;
    #1;
    chk("post_trap_fetch", e_fetch(3'd0, 1'b1));
    @(negedge clk);
    #1;
    chk("post_trap_dec", e_dec(3'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
